// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter sequencer for the fetch stage.
// Advances the PC each cycle, holds it on a decode hazard, and on a branch
// redirect loads the target and asserts flush_ifid for FLUSH_CYCLES cycles
// so that the wrong-path instructions already in IF/ID are squashed.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | sequential fetch, pc advances by one each cycle
// HOLD   | decode hazard, pc held and its re-fetch is marked not valid
// FLUSH  | redirect taken, IF/ID flushed, new path fetched sequentially
//
// Branch requests arriving during FLUSH come from wrong-path instructions
// and are dropped. The unused encoding 2'b11 falls back to RUN without
// disturbing pc.
module pc_fetch_ctrl #(
  parameter int                  PC_WIDTH     = 7,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_pc,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                fetch_valid,
  output logic                flush_ifid,
  output logic [7:0]          redirect_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_HOLD  = 2'b01,
    S_FLUSH = 2'b10
  } state_t;

  // The counter is loaded with FLUSH_CYCLES-1 and leaves FLUSH on the edge
  // where it reads zero, which yields exactly FLUSH_CYCLES flush cycles.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [2:0]          r_flush_cnt;
  logic                r_flush_ifid;
  logic                r_fetch_valid;
  logic [7:0]          r_redirect_count;

  logic [PC_WIDTH-1:0] w_pc_next;
  logic [7:0]          w_redirect_count_inc;

  // Sequential successor wraps naturally at the PC width.
  assign w_pc_next = r_pc + PC_WIDTH'(1);

  // Redirect counter saturates at 255.
  assign w_redirect_count_inc = (r_redirect_count == 8'hFF) ? r_redirect_count
                                                            : r_redirect_count + 8'd1;

  // Fetch FSM: pc, flush counter, and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_RUN;
      r_pc             <= RESET_PC;
      r_flush_cnt      <= 3'd0;
      r_flush_ifid     <= 1'b0;
      r_fetch_valid    <= 1'b1;
      r_redirect_count <= 8'd0;
    end else begin
      case (r_state)
        S_RUN, S_HOLD: begin
          if (branch_taken) begin
            r_pc             <= branch_pc;
            r_flush_cnt      <= FLUSH_LOAD;
            r_state          <= S_FLUSH;
            r_flush_ifid     <= 1'b1;
            r_fetch_valid    <= 1'b1;
            r_redirect_count <= w_redirect_count_inc;
          end else if (stall) begin
            r_state       <= S_HOLD;
            r_flush_ifid  <= 1'b0;
            r_fetch_valid <= 1'b0;
          end else begin
            r_pc          <= w_pc_next;
            r_state       <= S_RUN;
            r_flush_ifid  <= 1'b0;
            r_fetch_valid <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_pc          <= w_pc_next;
          r_fetch_valid <= 1'b1;
          if (r_flush_cnt == 3'd0) begin
            r_state      <= S_RUN;
            r_flush_ifid <= 1'b0;
          end else begin
            r_flush_cnt  <= r_flush_cnt - 3'd1;
            r_flush_ifid <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_RUN;
          r_flush_cnt   <= 3'd0;
          r_flush_ifid  <= 1'b0;
          r_fetch_valid <= 1'b1;
        end
      endcase
    end
  end

  assign pc             = r_pc;
  assign pc_next        = w_pc_next;
  assign fetch_valid    = r_fetch_valid;
  assign flush_ifid     = r_flush_ifid;
  assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a monitor pops and
// compares them on the falling edge (or on demand for async-reset checks).
module tb_pc_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [6:0] branch_pc = 7'd0;
  logic [6:0] pc;
  logic [6:0] pc_next;
  logic       fetch_valid;
  logic       flush_ifid;
  logic [7:0] redirect_count;

  pc_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_pc      (branch_pc),
    .pc             (pc),
    .pc_next        (pc_next),
    .fetch_valid    (fetch_valid),
    .flush_ifid     (flush_ifid),
    .redirect_count (redirect_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [6:0] pc;
    logic [6:0] pcn;
    logic       fv;
    logic       fl;
    logic [7:0] rc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always begin
    @(negedge clk or chk_now);
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.tag < cyc) begin
        errors++;
        $display("FAIL stale cyc=%0d tag=%0d expectation was never compared", cyc, e.tag);
      end else if (pc !== e.pc || pc_next !== e.pcn || fetch_valid !== e.fv ||
                   flush_ifid !== e.fl || redirect_count !== e.rc) begin
        errors++;
        $display("FAIL obs cyc=%0d got pc=%0d pc_next=%0d fv=%0b fl=%0b rc=%0d want pc=%0d pc_next=%0d fv=%0b fl=%0b rc=%0d",
                 cyc, pc, pc_next, fetch_valid, flush_ifid, redirect_count,
                 e.pc, e.pcn, e.fv, e.fl, e.rc);
      end
    end
  end

  task automatic push(input int tag, input logic [6:0] ep, input logic efv,
                      input logic efl, input logic [7:0] erc);
    exp_t e;
    e.tag = tag;
    e.pc  = ep;
    e.pcn = ep + 7'd1;
    e.fv  = efv;
    e.fl  = efl;
    e.rc  = erc;
    q.push_back(e);
  endtask

  // Drive inputs for one edge; expectation applies after that edge.
  task automatic step(input logic s, input logic b, input logic [6:0] bp,
                      input logic [6:0] ep, input logic efv, input logic efl,
                      input logic [7:0] erc);
    @(posedge clk);
    #1;
    stall        = s;
    branch_taken = b;
    branch_pc    = bp;
    push(cyc + 1, ep, efv, efl, erc);
  endtask

  // Check reset state while reset is high, then release; first edge counts.
  task automatic release_reset();
    @(posedge clk);
    #1;
    push(cyc, 7'd0, 1'b1, 1'b0, 8'd0);
    stall        = 1'b0;
    branch_taken = 1'b0;
    reset        = 1'b0;
    push(cyc + 1, 7'd1, 1'b1, 1'b0, 8'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout cyc=%0d queue=%0d", cyc, q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rc;
    logic [6:0] bp;

    release_reset();
    for (int p = 2; p <= 10; p++) step(1'b0, 1'b0, 7'd0, 7'(p), 1'b1, 1'b0, 8'd0);

    // Redirect at pc=10 to 40, two flush cycles.
    step(1'b0, 1'b1, 7'd40, 7'd40, 1'b1, 1'b1, 8'd1);
    step(1'b0, 1'b0, 7'd0,  7'd41, 1'b1, 1'b1, 8'd1);
    step(1'b0, 1'b0, 7'd0,  7'd42, 1'b1, 1'b0, 8'd1);

    // Get to pc=20, then stall three cycles.
    step(1'b0, 1'b1, 7'd18, 7'd18, 1'b1, 1'b1, 8'd2);
    step(1'b0, 1'b0, 7'd0,  7'd19, 1'b1, 1'b1, 8'd2);
    step(1'b0, 1'b0, 7'd0,  7'd20, 1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7'd0, 7'd20, 1'b0, 1'b0, 8'd2);
    step(1'b0, 1'b0, 7'd0,  7'd21, 1'b1, 1'b0, 8'd2);

    // Redirect out of HOLD, with stall still high.
    step(1'b1, 1'b0, 7'd0,   7'd21,  1'b0, 1'b0, 8'd2);
    step(1'b1, 1'b1, 7'd100, 7'd100, 1'b1, 1'b1, 8'd3);
    step(1'b0, 1'b0, 7'd0,   7'd101, 1'b1, 1'b1, 8'd3);
    step(1'b0, 1'b0, 7'd0,   7'd102, 1'b1, 1'b0, 8'd3);

    // Branch beats stall; stall and a second branch ignored in FLUSH.
    step(1'b1, 1'b1, 7'd5,  7'd5, 1'b1, 1'b1, 8'd4);
    step(1'b1, 1'b1, 7'd60, 7'd6, 1'b1, 1'b1, 8'd4);
    step(1'b1, 1'b0, 7'd0,  7'd7, 1'b1, 1'b0, 8'd4);
    step(1'b0, 1'b0, 7'd0,  7'd8, 1'b1, 1'b0, 8'd4);

    // Wrap 126 -> 127 -> 0 -> 1.
    step(1'b0, 1'b1, 7'd126, 7'd126, 1'b1, 1'b1, 8'd5);
    step(1'b0, 1'b0, 7'd0,   7'd127, 1'b1, 1'b1, 8'd5);
    step(1'b0, 1'b0, 7'd0,   7'd0,   1'b1, 1'b0, 8'd5);
    step(1'b0, 1'b0, 7'd0,   7'd1,   1'b1, 1'b0, 8'd5);

    // 300 redirects: count saturates at 255.
    rc = 8'd5;
    for (int k = 0; k < 300; k++) begin
      rc = (rc == 8'd255) ? 8'd255 : rc + 8'd1;
      bp = 7'(k * 3);
      step(1'b0, 1'b1, bp,   bp,         1'b1, 1'b1, rc);
      step(1'b0, 1'b0, 7'd0, bp + 7'd1,  1'b1, 1'b1, rc);
      step(1'b0, 1'b0, 7'd0, bp + 7'd2,  1'b1, 1'b0, rc);
    end

    // Asynchronous reset mid-FLUSH, off the clock edge.
    step(1'b0, 1'b1, 7'd50, 7'd50, 1'b1, 1'b1, 8'd255);
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    push(cyc, 7'd0, 1'b1, 1'b0, 8'd0);
    -> chk_now;
    release_reset();
    for (int p = 2; p <= 4; p++) step(1'b0, 1'b0, 7'd0, 7'(p), 1'b1, 1'b0, 8'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
